// File: rtl/clock_set_controller.sv
// Time-set controller: button pulses edit a copy of the running time, which is
// loaded back into the timekeeper on a long mode press or dropped after idling.
module clock_set_controller #(
    parameter int unsigned OneSec     = 50_000_000,
    parameter int unsigned TimeoutSec = 30
) (
    input  logic       CLOCK_50MHz,
    input  logic       RESETn,
    input  logic       MODE_Short,
    input  logic       MODE_Long,
    input  logic       INC_Short,
    input  logic       INC_Long,
    input  logic [4:0] CUR_Hour,
    input  logic [5:0] CUR_Min,
    input  logic [5:0] CUR_Sec,
    output logic [4:0] NEW_Hour,
    output logic [5:0] NEW_Min,
    output logic [5:0] NEW_Sec,
    output logic       LOAD,
    output logic       SetMode,
    output logic [1:0] FieldSel,
    output logic       Blink
);

    localparam int unsigned PrescW = (OneSec > 1) ? $clog2(OneSec) : 1;
    localparam int unsigned IdleW  = $clog2(TimeoutSec + 1);

    // Encoding doubles as the FieldSel value.
    typedef enum logic [1:0] {
        StNormal  = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10,
        StSetSec  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        new_hour_q, new_hour_d;
    logic [5:0]        new_min_q, new_min_d;
    logic [5:0]        new_sec_q, new_sec_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [IdleW-1:0]  idle_q, idle_d, idle_inc;
    logic              load_q, load_d;
    logic              blink_q, blink_d;

    logic       set_mode, any_pulse, accept, inc_en, presc_wrap, timeout;
    logic [3:0] step;
    logic [5:0] hour_sum;
    logic [6:0] min_sum, sec_sum;

    always_comb begin
        set_mode   = (state_q != StNormal);
        any_pulse  = MODE_Long | MODE_Short | INC_Long | INC_Short;
        accept     = set_mode ? any_pulse : MODE_Long;
        inc_en     = set_mode && !MODE_Long && !MODE_Short && (INC_Long || INC_Short);
        step       = INC_Long ? 4'd10 : 4'd1;
        presc_wrap = (presc_q == PrescW'(OneSec - 1));
        idle_inc   = idle_q + 1'b1;
        timeout    = set_mode && !any_pulse && presc_wrap && (idle_inc == IdleW'(TimeoutSec));
        // One bit of headroom so the sum cannot alias before the wrap.
        hour_sum   = {1'b0, new_hour_q} + 6'(step);
        min_sum    = {1'b0, new_min_q} + 7'(step);
        sec_sum    = {1'b0, new_sec_q} + 7'(step);
    end

    // State register
    always_ff @(posedge CLOCK_50MHz or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= StNormal;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; MODE_Long beats MODE_Short beats increments beats timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StNormal: begin
                if (MODE_Long) state_d = StSetHour;
            end
            StSetHour, StSetMin, StSetSec: begin
                if (MODE_Long) begin
                    state_d = StNormal;
                end else if (MODE_Short) begin
                    unique case (state_q)
                        StSetHour: state_d = StSetMin;
                        StSetMin:  state_d = StSetSec;
                        default:   state_d = StSetHour;
                    endcase
                end else if (timeout) begin
                    state_d = StNormal;
                end
            end
            default: state_d = StNormal;
        endcase
    end

    // Outputs
    always_comb begin
        SetMode  = set_mode;
        FieldSel = state_q;
        LOAD     = load_q;
        Blink    = blink_q;
        NEW_Hour = new_hour_q;
        NEW_Min  = new_min_q;
        NEW_Sec  = new_sec_q;
    end

    always_comb begin
        new_hour_d = new_hour_q;
        new_min_d  = new_min_q;
        new_sec_d  = new_sec_q;
        if (state_q == StNormal && MODE_Long) begin
            new_hour_d = CUR_Hour;
            new_min_d  = CUR_Min;
            new_sec_d  = CUR_Sec;
        end else if (inc_en) begin
            unique case (state_q)
                StSetHour: new_hour_d = (hour_sum >= 6'd24) ? 5'(hour_sum - 6'd24) : hour_sum[4:0];
                StSetMin:  new_min_d  = (min_sum >= 7'd60) ? 6'(min_sum - 7'd60) : min_sum[5:0];
                StSetSec:  new_sec_d  = (sec_sum >= 7'd60) ? 6'(sec_sum - 7'd60) : sec_sum[5:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        load_d = set_mode && MODE_Long;
        if (!set_mode || accept || timeout) begin
            presc_d = '0;
            idle_d  = '0;
            blink_d = 1'b0;
        end else begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            idle_d  = presc_wrap ? idle_inc : idle_q;
            blink_d = (presc_q == '0 || presc_q == PrescW'(OneSec / 2)) ? ~blink_q : blink_q;
        end
    end

    always_ff @(posedge CLOCK_50MHz or negedge RESETn) begin
        if (!RESETn) begin
            new_hour_q <= '0;
            new_min_q  <= '0;
            new_sec_q  <= '0;
            presc_q    <= '0;
            idle_q     <= '0;
            load_q     <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            new_hour_q <= new_hour_d;
            new_min_q  <= new_min_d;
            new_sec_q  <= new_sec_d;
            presc_q    <= presc_d;
            idle_q     <= idle_d;
            load_q     <= load_d;
            blink_q    <= blink_d;
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with a short second so timeouts are reachable.
module tb_clock_set_controller;

    logic       CLOCK_50MHz = 1'b0;
    logic       RESETn      = 1'b1;
    logic       MODE_Short  = 1'b0;
    logic       MODE_Long   = 1'b0;
    logic       INC_Short   = 1'b0;
    logic       INC_Long    = 1'b0;
    logic [4:0] CUR_Hour    = '0;
    logic [5:0] CUR_Min     = '0;
    logic [5:0] CUR_Sec     = '0;
    logic [4:0] NEW_Hour;
    logic [5:0] NEW_Min;
    logic [5:0] NEW_Sec;
    logic       LOAD;
    logic       SetMode;
    logic [1:0] FieldSel;
    logic       Blink;

    int n_tests = 0;
    int n_fail  = 0;
    int load_cnt = 0;

    clock_set_controller #(
        .OneSec     (10),
        .TimeoutSec (3)
    ) dut (
        .CLOCK_50MHz (CLOCK_50MHz),
        .RESETn      (RESETn),
        .MODE_Short  (MODE_Short),
        .MODE_Long   (MODE_Long),
        .INC_Short   (INC_Short),
        .INC_Long    (INC_Long),
        .CUR_Hour    (CUR_Hour),
        .CUR_Min     (CUR_Min),
        .CUR_Sec     (CUR_Sec),
        .NEW_Hour    (NEW_Hour),
        .NEW_Min     (NEW_Min),
        .NEW_Sec     (NEW_Sec),
        .LOAD        (LOAD),
        .SetMode     (SetMode),
        .FieldSel    (FieldSel),
        .Blink       (Blink)
    );

    always #5 CLOCK_50MHz = ~CLOCK_50MHz;

    always @(negedge CLOCK_50MHz) if (LOAD === 1'b1) load_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // p = {MODE_Long, MODE_Short, INC_Long, INC_Short}, held for one clock.
    task automatic pulse(input logic [3:0] p);
        @(negedge CLOCK_50MHz);
        {MODE_Long, MODE_Short, INC_Long, INC_Short} = p;
        @(negedge CLOCK_50MHz);
        {MODE_Long, MODE_Short, INC_Long, INC_Short} = 4'b0000;
    endtask

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return 32'((h << 12) | (m << 6) | s);
    endfunction

    function automatic logic [31:0] now();
        return {15'd0, NEW_Hour, NEW_Min, NEW_Sec};
    endfunction

    localparam logic [3:0] PML = 4'b1000, PMS = 4'b0100, PIL = 4'b0010, PIS = 4'b0001;

    initial begin
        int k;
        logic [19:0] bv;

        // Reset state
        #2 RESETn = 1'b0;
        #1;
        check("rst_new", now(), 0);
        check("rst_flags", {28'd0, LOAD, SetMode, FieldSel}, 0);
        check("rst_blink", Blink, 0);
        @(negedge CLOCK_50MHz) RESETn = 1'b1;

        // Entry captures CUR
        CUR_Hour = 5'd12; CUR_Min = 6'd34; CUR_Sec = 6'd56;
        pulse(PMS | PIS | PIL);
        check("normal_ignores", {30'd0, SetMode, 1'b0} | now(), 0);
        pulse(PML);
        check("entry_setmode", SetMode, 1);
        check("entry_field", FieldSel, 1);
        check("entry_capture", now(), hms(12, 34, 56));
        check("entry_blink", Blink, 0);
        CUR_Hour = 5'd1; CUR_Min = 6'd2; CUR_Sec = 6'd3;

        // Hour 12 + 12 ones wraps to 0
        repeat (12) pulse(PIS);
        check("hour_wrap_24", NEW_Hour, 0);
        check("cur_not_resampled", now(), hms(0, 34, 56));

        // Minute 55 + 10 -> 5
        pulse(PMS);
        check("field_min", FieldSel, 2);
        pulse(PIL); pulse(PIL); pulse(PIS);
        check("min_55", NEW_Min, 55);
        pulse(PIL);
        check("min_wrap_60", NEW_Min, 5);
        pulse(PMS);
        check("field_sec", FieldSel, 3);
        pulse(PMS);
        check("field_wraps_hour", FieldSel, 1);

        // Hour 18 + 10 -> 4
        pulse(PIL);
        repeat (8) pulse(PIS);
        check("hour_18", NEW_Hour, 18);
        pulse(PIL);
        check("hour_18p10", NEW_Hour, 4);

        // MODE_Short beats INC_Long
        pulse(PMS | PIL);
        check("prio_field", FieldSel, 2);
        check("prio_hour", NEW_Hour, 4);

        // Edit to 07:08:09
        repeat (3) pulse(PIS);
        pulse(PMS);
        pulse(PIL);
        repeat (3) pulse(PIS);
        check("sec_edit", NEW_Sec, 9);
        pulse(PMS);
        repeat (3) pulse(PIS);
        check("pre_load", now(), hms(7, 8, 9));
        check("no_load_yet", load_cnt, 0);
        @(negedge CLOCK_50MHz) MODE_Long = 1'b1;
        @(negedge CLOCK_50MHz) MODE_Long = 1'b0;
        check("load_high", LOAD, 1);
        check("load_field", FieldSel, 0);
        check("load_setmode", SetMode, 0);
        check("load_value", now(), hms(7, 8, 9));
        @(negedge CLOCK_50MHz);
        check("load_one_cycle", LOAD, 0);
        check("load_count", load_cnt, 1);
        pulse(PIS); pulse(PIL); pulse(PMS);
        check("normal_hold", now(), hms(7, 8, 9));

        // Idle timeout: 3 s of 10 cycles, blink period 10 cycles
        pulse(PML);
        check("to_entry", now(), hms(1, 2, 3));
        k = 0;
        bv = '0;
        do begin
            @(negedge CLOCK_50MHz);
            k++;
            if (k <= 20) bv[k-1] = Blink;
        end while (SetMode && k < 100);
        check("blink_wave", {12'd0, bv}, 32'h0007C1F);
        check("timeout_cycles", k, 30);
        check("timeout_no_load", load_cnt, 1);
        check("timeout_blink", Blink, 0);
        check("timeout_field", FieldSel, 0);

        // Async reset mid-edit in SET_SEC
        pulse(PML);
        pulse(PMS);
        pulse(PMS);
        pulse(PIS);
        check("pre_rst_field", FieldSel, 3);
        #2 RESETn = 1'b0;
        #1;
        check("async_new", now(), 0);
        check("async_flags", {28'd0, LOAD, SetMode, FieldSel}, 0);
        check("async_blink", Blink, 0);
        @(negedge CLOCK_50MHz) RESETn = 1'b1;
        repeat (3) @(negedge CLOCK_50MHz);
        check("post_rst_idle", {30'd0, SetMode, LOAD}, 0);
        check("post_rst_noload", load_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
